// File: rtl/dac_spi_monitor.sv
// Receive-side decoder for AD5320 SPI write frames: oversamples the pins on clk,
// reassembles 16-bit frames tagged with the HC4051 position, and flags short/long/stalled frames.
module dac_spi_monitor #(
   parameter int FRAME_BITS  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk_in,
   input  logic        sdata_in,
   input  logic        sync_n_in,
   input  logic [2:0]  pos_in,
   output logic        frame_valid,
   output logic [11:0] frame_data,
   output logic [1:0]  frame_pd,
   output logic [2:0]  frame_pos,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic [15:0] frame_count
);
   localparam int             BCW      = $clog2(FRAME_BITS + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS);
   localparam logic [BCW-1:0] PRE_LAST = BCW'(FRAME_BITS - 1);
   localparam logic [7:0]     TO_LAST  = 8'(TIMEOUT - 1);
   // Only PD and data survive; the two leading don't-care bits shift straight out.
   localparam int             PAY_W    = 14;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   logic [SYNC_STAGES-1:0]      sclk_sync, sdata_sync, sync_n_sync;
   logic [SYNC_STAGES-1:0][2:0] pos_sync;
   logic                        sclk_hist, sync_n_hist;
   logic                        sclk_s, sdata_s, sync_s;
   logic [2:0]                  pos_s;
   logic                        sclk_fall, sync_fall, sync_rise;

   // History flops reset low so a sync_n already low at release is not taken as a fresh edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync   <= '0;
         sdata_sync  <= '0;
         sync_n_sync <= '0;
         pos_sync    <= '0;
         sclk_hist   <= 1'b0;
         sync_n_hist <= 1'b0;
      end else begin
         sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
         sdata_sync  <= {sdata_sync[SYNC_STAGES-2:0], sdata_in};
         sync_n_sync <= {sync_n_sync[SYNC_STAGES-2:0], sync_n_in};
         pos_sync    <= {pos_sync[SYNC_STAGES-2:0], pos_in};
         sclk_hist   <= sclk_sync[SYNC_STAGES-1];
         sync_n_hist <= sync_n_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign sdata_s   = sdata_sync[SYNC_STAGES-1];
   assign sync_s    = sync_n_sync[SYNC_STAGES-1];
   assign pos_s     = pos_sync[SYNC_STAGES-1];
   assign sclk_fall = sclk_hist & ~sclk_s;
   assign sync_fall = sync_n_hist & ~sync_s;
   assign sync_rise = ~sync_n_hist & sync_s;

   state_t           state, state_nxt;
   logic [PAY_W-1:0] shreg, shreg_nxt;
   logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
   logic [7:0]       to_cnt, to_cnt_nxt;
   logic [2:0]       pos_start, pos_start_nxt;
   logic             long_done, long_done_nxt;
   logic             valid_nxt, err_nxt;
   logic [1:0]       err_code_nxt, pd_nxt;
   logic [11:0]      data_nxt;
   logic [2:0]       fpos_nxt;
   logic [15:0]      count_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         to_cnt      <= '0;
         pos_start   <= '0;
         long_done   <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= 2'b00;
         frame_data  <= '0;
         frame_pd    <= '0;
         frame_pos   <= '0;
         frame_count <= '0;
      end else begin
         state       <= state_nxt;
         shreg       <= shreg_nxt;
         bit_cnt     <= bit_cnt_nxt;
         to_cnt      <= to_cnt_nxt;
         pos_start   <= pos_start_nxt;
         long_done   <= long_done_nxt;
         frame_valid <= valid_nxt;
         frame_err   <= err_nxt;
         err_code    <= err_code_nxt;
         frame_data  <= data_nxt;
         frame_pd    <= pd_nxt;
         frame_pos   <= fpos_nxt;
         frame_count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      shreg_nxt     = shreg;
      bit_cnt_nxt   = bit_cnt;
      to_cnt_nxt    = to_cnt;
      pos_start_nxt = pos_start;
      long_done_nxt = long_done;
      valid_nxt     = 1'b0;
      err_nxt       = 1'b0;
      err_code_nxt  = err_code;
      data_nxt      = frame_data;
      pd_nxt        = frame_pd;
      fpos_nxt      = frame_pos;
      count_nxt     = frame_count;
      case (state)
         IDLE: begin
            if (sync_fall) begin
               state_nxt     = SHIFT;
               shreg_nxt     = '0;
               bit_cnt_nxt   = '0;
               to_cnt_nxt    = '0;
               pos_start_nxt = pos_s;
               long_done_nxt = 1'b0;
            end
         end
         SHIFT: begin
            if (bit_cnt == LAST_BIT) begin
               valid_nxt = 1'b1;
               data_nxt  = shreg[11:0];
               pd_nxt    = shreg[13:12];
               fpos_nxt  = pos_start;
               count_nxt = frame_count + 16'd1;
               // sync_n may already be back high if it rose together with the last edge.
               state_nxt = sync_s ? IDLE : HOLD;
            end else begin
               if (sclk_fall) begin
                  shreg_nxt   = {shreg[PAY_W-2:0], sdata_s};
                  bit_cnt_nxt = bit_cnt + 1'b1;
                  to_cnt_nxt  = '0;
               end else begin
                  to_cnt_nxt = to_cnt + 8'd1;
               end
               if (sync_rise && !(sclk_fall && bit_cnt == PRE_LAST)) begin
                  err_nxt      = 1'b1;
                  err_code_nxt = 2'b01;
                  state_nxt    = IDLE;
               end else if (!sclk_fall && to_cnt == TO_LAST) begin
                  err_nxt       = 1'b1;
                  err_code_nxt  = 2'b11;
                  long_done_nxt = 1'b1;
                  state_nxt     = HOLD;
               end
            end
         end
         HOLD: begin
            if (sync_rise) begin
               state_nxt = IDLE;
            end else if (sclk_fall && !sync_s && !long_done) begin
               err_nxt       = 1'b1;
               err_code_nxt  = 2'b10;
               long_done_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dac_spi_monitor.sv
// Bench for dac_spi_monitor: transaction-level driver predicts pulse timing and fields per frame,
// a single negedge process compares every output every cycle plus a few pinned literals.
module tb_dac_spi_monitor;
   logic        clk = 1'b0;
   logic        rst;
   logic        sclk_in, sdata_in, sync_n_in;
   logic [2:0]  pos_in;
   logic        frame_valid, frame_err;
   logic [11:0] frame_data;
   logic [1:0]  frame_pd, err_code;
   logic [2:0]  frame_pos;
   logic [15:0] frame_count;

   dac_spi_monitor dut (
      .clk(clk), .rst(rst), .sclk_in(sclk_in), .sdata_in(sdata_in), .sync_n_in(sync_n_in),
      .pos_in(pos_in), .frame_valid(frame_valid), .frame_data(frame_data), .frame_pd(frame_pd),
      .frame_pos(frame_pos), .frame_err(frame_err), .err_code(err_code), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected pulses keyed by the cycle in which they must be visible.
   logic [18:0] ev_v [int];   // {pos, word}
   logic [1:0]  ev_e [int];   // error code

   int errors = 0, checks = 0;
   int lit_step = 0, lit_done = 0;
   int preload_seq = 0, preload_seen = 0;

   logic [11:0] m_data;
   logic [1:0]  m_pd, m_code;
   logic [2:0]  m_pos;
   logic [15:0] m_count;
   logic [18:0] ev;
   bit          is_v, is_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         m_data = '0; m_pd = '0; m_pos = '0; m_code = '0; m_count = '0;
      end
      if (preload_seq != preload_seen) begin
         m_count      = 16'hFFFF;
         preload_seen = preload_seq;
      end
      is_v = !rst && ev_v.exists(cyc);
      is_e = !rst && ev_e.exists(cyc);
      if (is_v) begin
         ev      = ev_v[cyc];
         m_data  = ev[11:0];
         m_pd    = ev[13:12];
         m_pos   = ev[18:16];
         m_count = m_count + 16'd1;
      end
      if (is_e) m_code = ev_e[cyc];
      chk("frame_valid", 32'(frame_valid), 32'(is_v));
      chk("frame_err", 32'(frame_err), 32'(is_e));
      chk("frame_data", 32'(frame_data), 32'(m_data));
      chk("frame_pd", 32'(frame_pd), 32'(m_pd));
      chk("frame_pos", 32'(frame_pos), 32'(m_pos));
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("frame_count", 32'(frame_count), 32'(m_count));
      if (lit_step != lit_done) begin
         case (lit_step)
            1, 9: begin
               chk("rst_data", 32'(frame_data), 32'h0);
               chk("rst_pd_pos", 32'({frame_pd, frame_pos}), 32'h0);
               chk("rst_code_cnt", 32'({err_code, frame_count}), 32'h0);
            end
            2: begin
               chk("abc_data", 32'(frame_data), 32'hABC);
               chk("abc_pd", 32'(frame_pd), 32'h0);
               chk("abc_pos", 32'(frame_pos), 32'd5);
               chk("abc_count", 32'(frame_count), 32'd1);
            end
            3: begin
               chk("b2b_count", 32'(frame_count), 32'd8);
               chk("b2b_data", 32'(frame_data), 32'h707);
               chk("b2b_pos", 32'(frame_pos), 32'd7);
            end
            4: begin
               chk("short_code", 32'(err_code), 32'h1);
               chk("short_data_kept", 32'(frame_data), 32'h707);
               chk("short_count", 32'(frame_count), 32'd8);
            end
            5: begin
               chk("after_short_data", 32'(frame_data), 32'h456);
               chk("after_short_pd", 32'(frame_pd), 32'h2);
               chk("after_short_pos", 32'(frame_pos), 32'd2);
            end
            6: begin
               chk("long_code", 32'(err_code), 32'h2);
               chk("long_count", 32'(frame_count), 32'd10);
               chk("long_data", 32'(frame_data), 32'h123);
               chk("long_pd", 32'(frame_pd), 32'h3);
            end
            7: begin
               chk("timeout_code", 32'(err_code), 32'h3);
               chk("timeout_count", 32'(frame_count), 32'd10);
            end
            8: chk("wrap_count", 32'(frame_count), 32'h0);
            10: chk("post_rst_count", 32'(frame_count), 32'd1);
            default: ;
         endcase
         lit_done = lit_step;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lit(input int k);
      lit_step = k;
      tick(1);
   endtask

   // nedge SCLK falls, MSB first. simul: sync_n rises with the last edge. stall: hold sync_n low 300 cycles.
   task automatic send_frame(input logic [2:0] p, input logic [15:0] w, input int nedge,
                             input bit simul, input bit stall);
      int last;
      sync_n_in = 1'b0;
      pos_in    = p;
      last      = cyc;
      tick(4);
      pos_in = 3'($urandom_range(0, 7));
      tick(4);
      for (int i = 0; i < nedge; i++) begin
         sdata_in = (i < 16) ? w[15-i] : 1'($urandom_range(0, 1));
         tick(4);
         sclk_in = 1'b0;
         last    = cyc;
         if (i == 15) ev_v[cyc+4] = {p, w};
         if (i == 16) ev_e[cyc+3] = 2'b10;
         if (simul && i == nedge - 1) begin
            sync_n_in = 1'b1;
            if (nedge < 16) ev_e[cyc+3] = 2'b01;
         end
         tick(4);
         sclk_in = 1'b1;
      end
      if (!simul) begin
         if (stall) begin
            ev_e[last+258] = 2'b11;
            tick(296);
         end else begin
            tick(4);
         end
         sync_n_in = 1'b1;
         if (!stall && nedge < 16) ev_e[cyc+3] = 2'b01;
      end
      tick(8);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(4);
   endtask

   initial begin
      int r, n;
      rst = 1'b1; sclk_in = 1'b1; sdata_in = 1'b0; sync_n_in = 1'b1; pos_in = 3'd0;
      tick(4);
      lit(1);
      rst = 1'b0;
      tick(5);

      send_frame(3'd5, 16'h0ABC, 16, 1'b0, 1'b0);
      lit(2);

      pulse_rst();
      for (int p = 0; p < 8; p++) send_frame(3'(p), 16'(16'h0100 * p + p), 16, 1'b0, 1'b0);
      lit(3);

      send_frame(3'd3, 16'h1234, 10, 1'b0, 1'b0);
      lit(4);
      send_frame(3'd2, 16'h2456, 16, 1'b0, 1'b0);
      lit(5);

      send_frame(3'd6, 16'h3123, 17, 1'b0, 1'b0);
      lit(6);

      send_frame(3'd1, 16'h0F0F, 8, 1'b0, 1'b1);
      lit(7);

      force dut.frame_count = 16'hFFFF;
      preload_seq++;
      tick(3);
      release dut.frame_count;
      tick(2);
      send_frame(3'd4, 16'h1555, 16, 1'b0, 1'b0);
      lit(8);

      // Reset lands after the 9th edge; the rest of that frame must be ignored.
      sync_n_in = 1'b0; pos_in = 3'd7;
      tick(8);
      for (int i = 0; i < 16; i++) begin
         sdata_in = 1'($urandom_range(0, 1));
         tick(4);
         sclk_in = 1'b0;
         tick(4);
         sclk_in = 1'b1;
         if (i == 8) begin
            rst = 1'b1;
            tick(2);
            lit(9);
            rst = 1'b0;
         end
      end
      tick(4);
      sync_n_in = 1'b1;
      tick(8);
      send_frame(3'd2, 16'h0321, 16, 1'b0, 1'b0);
      lit(10);

      // Boundary: sync_n rising together with the 16th and with an earlier edge.
      send_frame(3'd5, 16'h2AAA, 16, 1'b1, 1'b0);
      send_frame(3'd6, 16'h1111, 10, 1'b1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         case (r)
            5: n = $urandom_range(1, 15);
            6: n = $urandom_range(17, 18);
            8: n = $urandom_range(1, 15);
            9: n = $urandom_range(0, 12);
            default: n = 16;
         endcase
         send_frame(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), n,
                    (r == 7 || r == 8), (r == 9 && k % 4 == 0));
      end
      tick(10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
